// File: rtl/la_trig_rle_capture.sv
// Logic-analyzer capture engine: trigger (immediate/pattern/edge), run-length encoding
// into a show-ahead FIFO with overflow gap markers, AXIS output and AXI-Lite control.
module la_trig_rle_capture #(
  parameter int NCH        = 24,
  parameter int RC_W       = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 12
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              axi_awvalid,
  input  logic              axi_wvalid,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [31:0]       axi_wdata,
  output logic              axi_awready,
  output logic              axi_wready,
  input  logic              axi_arvalid,
  input  logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arready,
  output logic              axi_rvalid,
  output logic [31:0]       axi_rdata,
  input  logic              axi_rready,
  input  logic              cc_la_enable,
  input  logic [NCH-1:0]    la_data,
  output logic [31:0]       m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [3:0]        m_tkeep,
  output logic [3:0]        m_tstrb,
  output logic [1:0]        m_tuser,
  output logic              la_hpri_req
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [RC_W-1:0]  RC_MAX  = '1;
  localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
  localparam logic [ADDR_W-3:0] R_CH_EN  = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] R_CTRL   = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] R_MASK   = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] R_VAL    = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] R_PKT    = (ADDR_W-2)'(4);
  localparam logic [ADDR_W-3:0] R_HTH    = (ADDR_W-2)'(5);
  localparam logic [ADDR_W-3:0] R_LTH    = (ADDR_W-2)'(6);
  localparam logic [ADDR_W-3:0] R_STATUS = (ADDR_W-2)'(7);
  localparam logic [ADDR_W-3:0] R_DROP   = (ADDR_W-2)'(8);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, FLUSH = 2'd3} state_t;
  state_t state, state_nxt;

  logic [NCH-1:0]    ch_en, trig_mask, trig_val;
  logic              ctrl_en;
  logic [1:0]        ctrl_mode;
  logic [7:0]        pkt_len, pkt_eff, tx_cnt;
  logic [15:0]       h_th, l_th, drop_cnt;
  logic              ovf_sticky, gap;
  logic [NCH-1:0]    s_p0, s_prev_p1, run_p1;
  logic [RC_W-1:0]   rc_p1;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [ADDR_W-3:0] wr_idx, rd_idx;
  logic              wr_en, status_wr, trig, load_run, cap_step, flush_push, run_end, data_req;
  logic              push_en, pop, drop, gap_set, gap_clr, not_full;
  logic [31:0]       push_word, data_word;
  logic              unused_bits;

  function automatic logic [RC_W-1:0] rc_sat_inc(input logic [RC_W-1:0] v);
    return (v == RC_MAX) ? v : v + RC_ONE;
  endfunction

  function automatic logic [15:0] cnt_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] pack_word(input logic [RC_W-1:0] rc, input logic [NCH-1:0] d);
    logic [31:0] w;
    w = '0;
    w[NCH+RC_W-1:NCH] = rc;
    w[NCH-1:0] = d;
    return w;
  endfunction

  assign unused_bits = ^{axi_rready, axi_awaddr[1:0], axi_araddr[1:0], axi_wdata};
  assign axi_awready = axi_awvalid & axi_wvalid;
  assign axi_wready  = axi_awvalid & axi_wvalid;
  assign axi_arready = axi_arvalid;
  assign axi_rvalid  = axi_arvalid;
  assign wr_idx      = axi_awaddr[ADDR_W-1:2];
  assign rd_idx      = axi_araddr[ADDR_W-1:2];
  assign wr_en       = axi_awvalid & axi_wvalid & cc_la_enable;
  assign status_wr   = wr_en && (wr_idx == R_STATUS);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      ch_en     <= '0;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      trig_mask <= '0;
      trig_val  <= '0;
      pkt_len   <= 8'd8;
      h_th      <= 16'(FIFO_DEPTH / 2);
      l_th      <= 16'd2;
    end else if (wr_en) begin
      case (wr_idx)
        R_CH_EN: ch_en <= axi_wdata[NCH-1:0];
        R_CTRL:  {ctrl_mode, ctrl_en} <= axi_wdata[2:0];
        R_MASK:  trig_mask <= axi_wdata[NCH-1:0];
        R_VAL:   trig_val <= axi_wdata[NCH-1:0];
        R_PKT:   pkt_len <= axi_wdata[7:0];
        R_HTH:   h_th <= axi_wdata[15:0];
        R_LTH:   l_th <= axi_wdata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    axi_rdata = 32'hFFFF_FFFF;
    case (rd_idx)
      R_CH_EN:  axi_rdata = 32'(ch_en);
      R_CTRL:   axi_rdata = {29'd0, ctrl_mode, ctrl_en};
      R_MASK:   axi_rdata = 32'(trig_mask);
      R_VAL:    axi_rdata = 32'(trig_val);
      R_PKT:    axi_rdata = {24'd0, pkt_len};
      R_HTH:    axi_rdata = {16'd0, h_th};
      R_LTH:    axi_rdata = {16'd0, l_th};
      R_STATUS: axi_rdata = {ovf_sticky, 7'd0, 16'(level), 6'd0, state};
      R_DROP:   axi_rdata = {16'd0, drop_cnt};
      default:  ;
    endcase
  end

  // Stage p0: masked sample; p1: previous sample, current run and its repeat count
  always_ff @(posedge axi_clk) begin
    s_p0      <= la_data & ch_en;
    s_prev_p1 <= s_p0;
    if (load_run || run_end) run_p1 <= s_p0;
    if (push_en) mem[wr_ptr] <= push_word;
  end

  always_comb begin
    case (ctrl_mode)
      2'd1:    trig = ((s_p0 & trig_mask) == (trig_val & trig_mask));
      2'd2:    trig = |((s_p0 ^ s_prev_p1) & trig_mask);
      default: trig = 1'b1;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_en) state_nxt = ARMED;
      ARMED:   if (!ctrl_en) state_nxt = IDLE;
               else if (trig) state_nxt = CAPTURE;
      CAPTURE: if (!ctrl_en) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_run   = 1'b0;
    cap_step   = 1'b0;
    flush_push = 1'b0;
    case (state)
      ARMED:   load_run = ctrl_en & trig;
      CAPTURE: cap_step = ctrl_en;
      FLUSH:   flush_push = 1'b1;
      default: ;
    endcase
  end

  assign run_end   = cap_step & ((s_p0 != run_p1) | (rc_p1 == RC_MAX));
  assign data_req  = run_end | flush_push;
  assign data_word = pack_word(rc_p1, run_p1);
  assign not_full  = (level != DEPTH_L);
  assign pop       = m_tvalid & m_tready;

  // While a gap is pending, the null marker takes the first free slot and data is dropped
  always_comb begin
    push_en   = 1'b0;
    push_word = data_word;
    drop      = 1'b0;
    gap_set   = 1'b0;
    gap_clr   = 1'b0;
    if (gap) begin
      drop = data_req;
      if (not_full) begin
        push_en   = 1'b1;
        push_word = 32'h0;
        gap_clr   = 1'b1;
      end
    end else if (data_req) begin
      if (not_full) push_en = 1'b1;
      else begin
        drop    = 1'b1;
        gap_set = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rc_p1       <= RC_ONE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      gap         <= 1'b0;
      ovf_sticky  <= 1'b0;
      drop_cnt    <= '0;
      tx_cnt      <= '0;
      la_hpri_req <= 1'b0;
    end else begin
      if (load_run) rc_p1 <= RC_ONE;
      else if (cap_step) rc_p1 <= run_end ? RC_ONE : rc_sat_inc(rc_p1);
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
      if (gap_set) gap <= 1'b1;
      else if (gap_clr) gap <= 1'b0;
      if (status_wr) begin
        ovf_sticky <= 1'b0;
        drop_cnt   <= '0;
      end else if (drop) begin
        ovf_sticky <= 1'b1;
        drop_cnt   <= cnt_sat_inc(drop_cnt);
      end
      if (pop) tx_cnt <= m_tlast ? 8'd0 : tx_cnt + 8'd1;
      if (16'(level) >= h_th) la_hpri_req <= 1'b1;
      else if (16'(level) < l_th) la_hpri_req <= 1'b0;
    end
  end

  assign pkt_eff  = (pkt_len == 8'd0) ? 8'd1 : pkt_len;
  assign m_tvalid = (level != '0);
  assign m_tdata  = mem[rd_ptr];
  assign m_tlast  = m_tvalid & ((tx_cnt == pkt_eff - 8'd1) | ((state == IDLE) & (level == LVL_ONE)));
  assign m_tkeep  = 4'hF;
  assign m_tstrb  = 4'hF;
  assign m_tuser  = 2'b00;
endmodule
